// File: rtl/sdf_pkg.sv
// Shared types and constants for the sdf distance pipeline and its front-end arbiter.
// Points are carried as raw 27-bit float bit patterns; no arithmetic is done on them here.
package sdf_pkg;

    localparam int FLOAT_W = 27;
    localparam int MAX_REQ = 8;

    typedef logic [FLOAT_W-1:0] float_t;

    typedef struct packed {
        float_t x;
        float_t y;
        float_t z;
    } point_t;

    localparam float_t FLOAT_ONE  = 27'h1fc0000;
    localparam float_t FLOAT_ZERO = 27'h0000000;
    localparam point_t POINT_ZERO = '{x: FLOAT_ZERO, y: FLOAT_ZERO, z: FLOAT_ZERO};

    // Encodes a one-hot (or all-zero) vector to its bit index; all-zero maps to 0.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (vec[i]) begin
                idx = idx | 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the last accepted index.
// The pointer moves only when the caller reports that the grant was taken.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] last_q;
    logic [IW-1:0] last_d;
    logic [IW-1:0] sel_s;
    logic [IW-1:0] idx_s;
    logic          found_s;

    // Scan last_q+1 .. last_q+N (wrapping); the first requester found wins.
    always_comb begin
        grant   = '0;
        sel_s   = last_q;
        idx_s   = last_q;
        found_s = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx_s = IW'((32'(last_q) + 32'(k)) % 32'(N));
            if (!found_s && req[idx_s]) begin
                found_s      = 1'b1;
                grant[idx_s] = 1'b1;
                sel_s        = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer next-state: only an accepted grant moves priority on.
    always_comb begin
        if (advance) begin
            last_d = sel_s;
        end else begin
            last_d = last_q;
        end
    end

    // Pointer register; reset to N-1 so requester 0 is first in line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= IW'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sdf_arbiter.sv
// Shares one fixed-latency sdf pipeline between NUM_REQ marcher cores; a tag delay line
// matched to the pipeline depth routes each returned distance back to its issuing core.
module sdf_arbiter
    import sdf_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int SDF_LATENCY     = 11,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*FLOAT_W-1:0] req_x,
    input  logic [NUM_REQ*FLOAT_W-1:0] req_y,
    input  logic [NUM_REQ*FLOAT_W-1:0] req_z,
    output logic [FLOAT_W-1:0]         sdf_point_x,
    output logic [FLOAT_W-1:0]         sdf_point_y,
    output logic [FLOAT_W-1:0]         sdf_point_z,
    input  logic [FLOAT_W-1:0]         sdf_distance,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [FLOAT_W-1:0]         resp_distance,
    output logic                       busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = 4;
    localparam int DEPTH = SDF_LATENCY + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [NUM_REQ-1:0] eligible_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [NUM_REQ-1:0] accept_vec_s;
    logic [NUM_REQ-1:0] retire_vec_s;
    logic               accept_s;
    logic [ID_W-1:0]    accept_id_s;
    logic               retire_s;
    logic [ID_W-1:0]    retire_id_s;

    point_t             req_pt_s;
    point_t             pt_q;
    point_t             pt_d;

    logic [DEPTH-1:0]   tag_vld_q;
    logic [DEPTH-1:0]   tag_vld_d;
    logic [ID_W-1:0]    tag_id_q [DEPTH];
    logic [ID_W-1:0]    tag_id_d [DEPTH];

    logic [CNT_W-1:0]   cnt_q [NUM_REQ];
    logic [CNT_W-1:0]   cnt_d [NUM_REQ];

    logic [NUM_REQ-1:0] resp_vld_q;
    logic [NUM_REQ-1:0] resp_vld_d;
    float_t             resp_dist_q;
    float_t             resp_dist_d;
    logic               busy_q;
    logic               busy_d;

    // A core competes only while it is below its in-flight limit.
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible_s[i] = req_valid[i] && (cnt_q[i] < CNT_MAX);
        end
    end

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (eligible_s),
        .advance (accept_s),
        .grant   (grant_s)
    );

    assign req_ready    = grant_s & {NUM_REQ{rst_n}};
    assign accept_vec_s = req_valid & req_ready;
    assign accept_s     = |accept_vec_s;
    assign accept_id_s  = ID_W'(onehot_to_idx(MAX_REQ'(accept_vec_s)));

    // Pick the accepted core's point out of the packed request buses.
    always_comb begin
        req_pt_s = POINT_ZERO;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept_vec_s[i]) begin
                req_pt_s.x = req_x[i*FLOAT_W +: FLOAT_W];
                req_pt_s.y = req_y[i*FLOAT_W +: FLOAT_W];
                req_pt_s.z = req_z[i*FLOAT_W +: FLOAT_W];
            end else begin
                req_pt_s = req_pt_s;
            end
        end
    end

    // The pipeline input holds its last point on idle cycles.
    always_comb begin
        if (accept_s) begin
            pt_d = req_pt_s;
        end else begin
            pt_d = pt_q;
        end
    end

    // Tag line: stage 0 lines up with sdf_point_*, the last stage with sdf_distance.
    always_comb begin
        tag_vld_d[0] = accept_s;
        tag_id_d[0]  = accept_id_s;
        for (int k = 1; k < DEPTH; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_id_d[k]  = tag_id_q[k-1];
        end
    end

    assign retire_s    = tag_vld_q[DEPTH-1];
    assign retire_id_s = tag_id_q[DEPTH-1];

    // Decode the emerging tag into a one-hot retire vector.
    always_comb begin
        retire_vec_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            retire_vec_s[i] = retire_s && (retire_id_s == ID_W'(i));
        end
    end

    // In-flight counters; accept and retire in the same cycle cancel out.
    always_comb begin
        busy_d = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            case ({accept_vec_s[i], retire_vec_s[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
            busy_d = busy_d | (cnt_d[i] != '0);
        end
    end

    // Response capture; distance holds between pulses.
    always_comb begin
        resp_vld_d = retire_vec_s;
        if (retire_s) begin
            resp_dist_d = sdf_distance;
        end else begin
            resp_dist_d = resp_dist_q;
        end
    end

    // State registers; reset discards every in-flight tag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pt_q        <= POINT_ZERO;
            tag_vld_q   <= '0;
            resp_vld_q  <= '0;
            resp_dist_q <= FLOAT_ZERO;
            busy_q      <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                tag_id_q[k] <= '0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pt_q        <= pt_d;
            tag_vld_q   <= tag_vld_d;
            resp_vld_q  <= resp_vld_d;
            resp_dist_q <= resp_dist_d;
            busy_q      <= busy_d;
            for (int k = 0; k < DEPTH; k++) begin
                tag_id_q[k] <= tag_id_d[k];
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sdf_point_x   = pt_q.x;
    assign sdf_point_y   = pt_q.y;
    assign sdf_point_z   = pt_q.z;
    assign resp_valid    = resp_vld_q;
    assign resp_distance = resp_dist_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_sdf_arbiter.sv
// Directed bench for sdf_arbiter: a latency-11 sdf stand-in returns x^y^z of each point,
// and a scoreboard keyed by core id checks routing, ordering, latency and values.
`timescale 1ns/1ps
module tb_sdf_arbiter;
    import sdf_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 11;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N*FLOAT_W-1:0] req_x, req_y, req_z;
    logic [FLOAT_W-1:0]   px, py, pz;
    logic [FLOAT_W-1:0]   sdf_distance;
    logic [N-1:0]         resp_valid;
    logic [FLOAT_W-1:0]   resp_distance;
    logic                 busy;

    int          tests = 0;
    int          fails = 0;
    int          pulses = 0;
    int unsigned cyc = 0;
    bit          sb_on = 1'b0;
    bit          rand_pts = 1'b1;

    float_t dpipe [LAT];
    float_t ptx [N];
    float_t pty [N];
    float_t ptz [N];

    typedef struct { int id; float_t d; int unsigned c; } exp_t;
    exp_t sbq [$];

    typedef struct { int idle; bit rst; logic [N-1:0] v; logic [N-1:0] rdy; logic bsy; } vec_t;
    vec_t tbl [$];

    sdf_arbiter #(.NUM_REQ(N), .SDF_LATENCY(LAT), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .sdf_point_x(px), .sdf_point_y(py), .sdf_point_z(pz),
        .sdf_distance(sdf_distance), .resp_valid(resp_valid),
        .resp_distance(resp_distance), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in sdf: distance = x ^ y ^ z, LAT cycles after the point is presented.
    always @(posedge clk) begin
        dpipe[0] <= px ^ py ^ pz;
        for (int k = 1; k < LAT; k++) dpipe[k] <= dpipe[k-1];
    end
    assign sdf_distance = dpipe[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: retire responses in per-core issue order, then record new accepts.
    always @(negedge clk) begin : sb
        int   rid;
        int   hit;
        exp_t e;
        rid = 0;
        hit = -1;
        if (sb_on) begin
            if (resp_valid != '0) begin
                pulses++;
                check("resp_onehot", 32'($countones(resp_valid)), 32'd1);
                for (int i = 0; i < N; i++) if (resp_valid[i]) rid = i;
                for (int j = 0; j < sbq.size(); j++) if (hit < 0 && sbq[j].id == rid) hit = j;
                if (hit < 0) begin
                    tests++;
                    fails++;
                    $display("FAIL resp_unexpected: pulse on core %0d, expected none", rid);
                end else begin
                    check($sformatf("resp_dist_c%0d", rid), 32'(resp_distance), 32'(sbq[hit].d));
                    check("resp_latency", cyc - sbq[hit].c, 32'd13);
                    sbq.delete(hit);
                end
            end
            if ((req_valid & req_ready) != '0) begin
                check("accept_onehot", 32'($countones(req_valid & req_ready)), 32'd1);
                for (int i = 0; i < N; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        e.id = i;
                        e.d  = req_x[i*FLOAT_W +: FLOAT_W] ^ req_y[i*FLOAT_W +: FLOAT_W]
                             ^ req_z[i*FLOAT_W +: FLOAT_W];
                        e.c  = cyc;
                        sbq.push_back(e);
                    end
                end
            end
            if (!rst_n) sbq.delete();
        end
    end

    task automatic new_pt(input int i);
        if (rand_pts) begin
            ptx[i] = FLOAT_W'($urandom);
            pty[i] = FLOAT_W'($urandom);
            ptz[i] = FLOAT_W'($urandom);
        end else begin
            ptx[i] = FLOAT_ONE;
            pty[i] = FLOAT_ZERO;
            ptz[i] = FLOAT_ZERO;
        end
    endtask

    // One cycle: drive at posedge+1, sample at negedge, refresh points of accepted cores.
    task automatic tick(input logic [N-1:0] v, output logic [N-1:0] rdy, output logic bsy,
                        output logic [N-1:0] rv);
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_x[i*FLOAT_W +: FLOAT_W] = ptx[i];
            req_y[i*FLOAT_W +: FLOAT_W] = pty[i];
            req_z[i*FLOAT_W +: FLOAT_W] = ptz[i];
        end
        @(negedge clk);
        rdy = req_ready;
        bsy = busy;
        rv  = resp_valid;
        for (int i = 0; i < N; i++) if (v[i] && rdy[i]) new_pt(i);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic add(input int idle, input bit rst, input logic [N-1:0] v,
                       input logic [N-1:0] rdy, input logic bsy);
        vec_t e;
        e.idle = idle; e.rst = rst; e.v = v; e.rdy = rdy; e.bsy = bsy;
        tbl.push_back(e);
    endtask

    initial begin : main
        logic [N-1:0] rdy;
        logic [N-1:0] rv;
        logic         bsy;

        for (int i = 0; i < N; i++) new_pt(i);
        for (int k = 0; k < LAT; k++) dpipe[k] = '0;
        req_valid = '1;
        req_x = '0; req_y = '0; req_z = '0;

        // Arbitration walk from reset, including a core at its limit being skipped.
        add(0, 1, 4'b0000, 4'b0000, 1'b0);
        add(0, 0, 4'b1111, 4'b0001, 1'b0);
        add(0, 0, 4'b1110, 4'b0010, 1'b1);
        add(0, 0, 4'b1010, 4'b1000, 1'b1);
        add(0, 0, 4'b0011, 4'b0001, 1'b1);
        add(0, 0, 4'b0011, 4'b0010, 1'b1);
        add(0, 0, 4'b0001, 4'b0001, 1'b1);
        add(0, 0, 4'b0001, 4'b0001, 1'b1);
        add(0, 0, 4'b0001, 4'b0000, 1'b1);
        add(0, 0, 4'b0011, 4'b0010, 1'b1);
        add(0, 0, 4'b0000, 4'b0000, 1'b1);
        // Core 1 saturates, core 2 takes its slot; core 1 returns the cycle after its retire.
        add(20, 1, 4'b0010, 4'b0010, 1'b0);
        add(0, 0, 4'b0010, 4'b0010, 1'b1);
        add(0, 0, 4'b0010, 4'b0010, 1'b1);
        add(0, 0, 4'b0010, 4'b0010, 1'b1);
        add(0, 0, 4'b0110, 4'b0100, 1'b1);
        for (int c = 5; c < 12; c++) add(0, 0, 4'b0010, 4'b0000, 1'b1);
        add(0, 0, 4'b0110, 4'b0100, 1'b1);
        add(0, 0, 4'b0110, 4'b0010, 1'b1);
        // Core 0 accepts while retiring at count 2: count stays 2, visible as 3 more accepts.
        add(20, 1, 4'b0001, 4'b0001, 1'b0);
        add(0, 0, 4'b0001, 4'b0001, 1'b1);
        add(10, 0, 4'b0001, 4'b0001, 1'b1);
        add(0, 0, 4'b0000, 4'b0000, 1'b1);
        add(0, 0, 4'b0001, 4'b0001, 1'b1);
        add(0, 0, 4'b0001, 4'b0001, 1'b1);
        add(0, 0, 4'b0001, 4'b0001, 1'b1);
        add(0, 0, 4'b0001, 4'b0000, 1'b1);

        // Reset state, with every core requesting.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_distance", 32'(resp_distance), 32'd0);
        check("rst_point", 32'(px | py | pz), 32'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n = 1'b1;
        sb_on = 1'b1;

        for (int r = 0; r < tbl.size(); r++) begin
            repeat (tbl[r].idle) tick('0, rdy, bsy, rv);
            if (tbl[r].rst) do_reset(2);
            tick(tbl[r].v, rdy, bsy, rv);
            check($sformatf("tbl%0d_ready", r), 32'(rdy), 32'(tbl[r].rdy));
            check($sformatf("tbl%0d_busy", r), 32'(bsy), 32'(tbl[r].bsy));
        end

        // Single core holding (1.0, 0, 0): 4 accepts, stall, resume when the first returns.
        repeat (20) tick('0, rdy, bsy, rv);
        rand_pts = 1'b0;
        new_pt(0);
        for (int c = 0; c < 14; c++) begin
            tick(4'b0001, rdy, bsy, rv);
            check($sformatf("single_ready_c%0d", c), 32'(rdy[0]), 32'((c < 4) || (c == 13)));
            if (c == 12) check("single_no_early_resp", 32'(rv), 32'd0);
            if (c == 13) check("single_first_resp", 32'(rv), 32'b0001);
        end
        repeat (20) tick('0, rdy, bsy, rv);
        rand_pts = 1'b1;

        // All cores requesting continuously: strict rotation, one accept per cycle.
        do_reset(2);
        for (int k = 0; k < 40; k++) begin
            tick(4'b1111, rdy, bsy, rv);
            check($sformatf("rotate_k%0d", k), 32'(rdy), 32'(1 << (k % 4)));
        end

        // One-cycle reset with many requests in flight: all of them are dropped.
        req_valid = 4'b1111;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_grant", 32'(req_ready), 32'b0001);
        check("post_rst_busy", 32'(busy), 32'd0);
        req_valid = '0;
        pulses = 0;
        repeat (20) tick('0, rdy, bsy, rv);
        check("post_rst_pulses", 32'(pulses), 32'd0);
        check("post_rst_idle_busy", 32'(bsy), 32'd0);

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdf_arbiter.md
# sdf_arbiter

Shares one fixed-latency, non-stallable `sdf` distance pipeline between `NUM_REQ` ray-march cores. Each cycle the block grants at most one requester by round-robin, registers that requester's 27-bit float sample point into the pipeline, and carries a tag through a delay line matched to the pipeline depth. The tag routes the returned distance back to the originating core. The block sits between the per-pixel marcher cores and the single `sdf` instance.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesting cores (2..8).
- `SDF_LATENCY`, 11: cycles from `sdf` point inputs to `distance` output; must equal the instantiated scene's pipeline depth.
- `MAX_OUTSTANDING`, 4: in-flight limit per requester (1..15).

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `req_valid`, in, NUM_REQ: per-core request.
- `req_ready`, out, NUM_REQ: one-hot grant; the request is accepted when `req_valid[i] & req_ready[i]`.
- `req_x`/`req_y`/`req_z`, in, NUM_REQ*27 each: packed points; requester i occupies bits [27i+26:27i].
- `sdf_point_x`/`_y`/`_z`, out, 27 each: registered point driven to `sdf`.
- `sdf_distance`, in, 27: `sdf` output.
- `resp_valid`, out, NUM_REQ: one-hot, one-cycle pulse.
- `resp_distance`, out, 27: returned distance, shared by all cores and qualified by `resp_valid`.
- `busy`, out, 1: high if any request is in flight.

## Operation
- Eligibility: requester i is eligible when `req_valid[i]` is high and `outstanding[i] < MAX_OUTSTANDING`.
- Grant selection: round-robin over eligible requesters, searching upward from `last_grant+1` with wrap.
  - `last_grant` updates only on an accepted request.
  - `last_grant` resets to NUM_REQ-1, so requester 0 has top priority first.
- `req_ready` is combinational from `req_valid`, the counters and `last_grant`. Requesters must not make `req_valid` depend on `req_ready`. Once raised, `req_valid` and the point must hold until accepted.
- On accept: the point is registered onto `sdf_point_*`. Tag {valid=1, id} enters stage 0 of a `SDF_LATENCY+1`-deep tag delay line.
- With no accept: `sdf_point_*` holds its previous value and a tag with valid=0 enters the line.
- The tag emerging from the delay line aligns with `sdf_distance`.
  - If its valid bit is set, register `resp_distance <= sdf_distance` and pulse `resp_valid[id]`.
  - Otherwise `resp_valid` is all zero and `resp_distance` holds.
- Responses cannot be back-pressured; cores must always sink them. Results for a given requester return in issue order.
- `outstanding[i]`: increments on accept and decrements on response retire. A simultaneous accept and retire for the same i leaves the count unchanged.
- A retire in the current cycle does not make the requester eligible until the next cycle.
- `busy` = OR over all counters being nonzero.
- No float arithmetic in this block; values pass through bit-exact.

## Timing
- Throughput: one accept per cycle across all requesters.
- Latency: accept at cycle t -> `sdf_point_*` valid at t+1 -> `resp_valid`/`resp_distance` at t+2+SDF_LATENCY. Default: 13 cycles.
- Reset values:
  - `sdf_point_*` = 0
  - `resp_valid` = 0
  - `resp_distance` = 0
  - all tag valids = 0
  - counters = 0
  - `last_grant` = NUM_REQ-1
  - `busy` = 0
  - `req_ready` = 0 during reset
- Reset mid-operation: all in-flight tags are discarded and no responses are emitted for them. Stale data still draining from `sdf` is ignored because its tags are invalid.
- At `MAX_OUTSTANDING`: the requester is skipped and arbitration passes to the next eligible core in the same cycle; there is no idle bubble.
- Single eligible requester: granted every cycle until its limit is reached.

## Structure
- Shared package `sdf_pkg`:
  - `FLOAT_W = 27`
  - `typedef` for the 27-bit float and for the point {x,y,z}
  - constants `FLOAT_ONE = 27'h1fc0000`, `FLOAT_ZERO = 0`
- Sub-module `rr_arbiter`: parameter N; inputs `req[N]`, `advance`; outputs one-hot `grant[N]`; owns the `last_grant` pointer.
- Tag delay line and per-requester counters are in the top level.

## Test plan
- Single core: `req_valid[0]` held with point (1.0, 0, 0), SDF_LATENCY=11 -> first `resp_valid[0]` 13 cycles after the first accept. `resp_distance` equals the `sdf_distance` sampled 12 cycles after accept. The core stalls after 4 accepts until the first response returns.
- All 4 cores valid continuously -> grant order 0,1,2,3,0,… with one accept per cycle. Each core receives exactly every 4th response, in order.
- Core 1 at `MAX_OUTSTANDING` while cores 1 and 2 are valid -> core 2 is granted the same cycle. In the cycle core 1 retires and core 2 accepts, core 1's count drops to 3 and core 1 is eligible on the following cycle.
- Same-cycle accept and retire on core 0 with count 2 -> count stays 2 and `busy` stays 1.
- Assert `rst_n`=0 for 1 cycle with 8 requests in flight -> zero `resp_valid` pulses for the following 20 cycles. Counters are 0, `busy`=0, and the first post-reset grant goes to core 0.
- Bit-exactness: random `sdf_distance` values driven by a latency-11 model with one-hot IDs -> every `resp_distance` matches the model and is routed to the correct core.
